// File: rtl/regfile_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_ctrl                                               |
// | Description : Sequencer between a write-back port, an operand-read port  |
// |               and a single-ported 32x32 register file. Write-backs take  |
// |               one WRITE cycle; reads go READ -> CAPTURE -> RESP.         |
// | Options     : RF_R0_ZERO_EN - r0 hard-wired to zero (writes suppressed,  |
// |               reads of address 0 return 0).                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_ctrl (
   input  logic        clk,
   input  logic        rst,
   // write-back request
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   // operand-read request
   input  logic        rd_valid,
   output logic        rd_ready,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   // operand response
   output logic        op_valid,
   input  logic        op_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   // register-file side
   output logic [31:0] rf_in_reg,
   output logic [4:0]  rf_addr_a,
   output logic [4:0]  rf_addr_b,
   output logic        rf_rw,
   output logic        rf_sel,
   input  logic [31:0] rf_out_a,
   input  logic [31:0] rf_out_b,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WRITE   = 3'd1,
      S_READ    = 3'd2,
      S_CAPTURE = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        rf_sel_q, rf_sel_d;
   logic        rf_rw_q, rf_rw_d;
   logic [31:0] rf_in_reg_q, rf_in_reg_d;
   logic [4:0]  rf_addr_a_q, rf_addr_a_d;
   logic [4:0]  rf_addr_b_q, rf_addr_b_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic        wb_sel_n;

   // Handshake and status flags derive from the current state; a write-back
   // masks the read port so it always wins a simultaneous request.
   assign wb_ready = (state_q == S_IDLE) && !rst;
   assign rd_ready = wb_ready && !wb_valid;
   assign busy     = (state_q != S_IDLE);
   assign op_valid = (state_q == S_RESP);

   assign rf_sel    = rf_sel_q;
   assign rf_rw     = rf_rw_q;
   assign rf_in_reg = rf_in_reg_q;
   assign rf_addr_a = rf_addr_a_q;
   assign rf_addr_b = rf_addr_b_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;

`ifdef RF_R0_ZERO_EN
   // r0 is constant zero: keep the chip deselected for a write to it
   assign wb_sel_n = (wb_addr == 5'd0);
`else
   assign wb_sel_n = 1'b0;
`endif

   // Next-state and next-output computation; the rf_* pins are registered so
   // their values for a state are prepared on the edge that enters it.
   always_comb begin
      state_d     = state_q;
      rf_sel_d    = 1'b1;
      rf_rw_d     = 1'b1;
      rf_in_reg_d = 32'h0;
      rf_addr_a_d = rf_addr_a_q;
      rf_addr_b_d = rf_addr_b_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      case (state_q)
         S_IDLE: begin
            if (wb_valid && wb_ready) begin
               state_d     = S_WRITE;
               rf_sel_d    = wb_sel_n;
               rf_rw_d     = 1'b0;
               rf_addr_a_d = wb_addr;
               rf_in_reg_d = wb_data;
            end else if (rd_valid && rd_ready) begin
               state_d     = S_READ;
               rf_sel_d    = 1'b0;
               rf_rw_d     = 1'b1;
               rf_addr_a_d = rd_addr_a;
               rf_addr_b_d = rd_addr_b;
            end
         end
         S_WRITE: begin
            state_d = S_IDLE;
         end
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // rf_addr_* still hold the read addresses here
`ifdef RF_R0_ZERO_EN
            op_a_d = (rf_addr_a_q == 5'd0) ? 32'h0 : rf_out_a;
            op_b_d = (rf_addr_b_q == 5'd0) ? 32'h0 : rf_out_b;
`else
            op_a_d = rf_out_a;
            op_b_d = rf_out_b;
`endif
            state_d = S_RESP;
         end
         S_RESP: begin
            if (op_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rf_sel_q    <= 1'b1;
         rf_rw_q     <= 1'b1;
         rf_in_reg_q <= 32'h0;
         rf_addr_a_q <= 5'd0;
         rf_addr_b_q <= 5'd0;
         op_a_q      <= 32'h0;
         op_b_q      <= 32'h0;
      end else begin
         state_q     <= state_d;
         rf_sel_q    <= rf_sel_d;
         rf_rw_q     <= rf_rw_d;
         rf_in_reg_q <= rf_in_reg_d;
         rf_addr_a_q <= rf_addr_a_d;
         rf_addr_b_q <= rf_addr_b_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
      end
   end

endmodule
`default_nettype wire
